// File: rtl/lc4_dmem_arbiter.sv
// lc4_dmem_arbiter: shares the lc4_memory data port between the processor
// and a host requester. The processor has priority. A host that keeps losing
// under contention is granted after STARVE_LIMIT lost gwe cycles. All state
// advances on gwe edges only.
module lc4_dmem_arbiter #(
  parameter int WORD_SIZE     = 64,
  parameter int REG_ADDR_BITS = 3,
  parameter int STARVE_LIMIT  = 3,
  parameter int CNT_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     gwe,
  // processor side
  input  logic                     p_req,
  input  logic                     p_we,
  input  logic [REG_ADDR_BITS-1:0] p_raddr,
  input  logic [REG_ADDR_BITS-1:0] p_waddr,
  input  logic [WORD_SIZE-1:0]     p_wdata,
  output logic [WORD_SIZE-1:0]     p_rdata,
  output logic                     p_stall,
  // host side
  input  logic                     h_req,
  input  logic                     h_we,
  input  logic [REG_ADDR_BITS-1:0] h_addr,
  input  logic [WORD_SIZE-1:0]     h_wdata,
  output logic                     h_ack,
  output logic [WORD_SIZE-1:0]     h_rdata,
  output logic                     h_rvalid,
  // memory side
  output logic [REG_ADDR_BITS-1:0] mem_raddr,
  output logic [REG_ADDR_BITS-1:0] mem_waddr,
  output logic [WORD_SIZE-1:0]     mem_din,
  output logic                     mem_we,
  input  logic [WORD_SIZE-1:0]     mem_dout,
  // statistics
  output logic [CNT_W-1:0]         stat_host_grants,
  output logic [CNT_W-1:0]         stat_proc_stalls
);

  localparam int SW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]    STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [SW-1:0] starve_cnt;
  logic          host_sel;

  // Host wins when the processor is idle or the host has lost enough times.
  assign host_sel = h_req && (!p_req || (starve_cnt == STARVE_MAX));
  assign p_stall  = p_req && host_sel;
  assign h_ack    = host_sel && gwe;
  assign p_rdata  = mem_dout;

  // Port mux: the owner of this gwe cycle drives address, data and enable.
  always_comb begin
    mem_raddr = p_raddr;
    mem_waddr = p_waddr;
    mem_din   = p_wdata;
    mem_we    = p_req && p_we;
    if (host_sel) begin
      mem_raddr = h_addr;
      mem_waddr = h_addr;
      mem_din   = h_wdata;
      mem_we    = h_we;
    end
  end

  // Starvation counter: counts consecutive contended losses, cleared on grant
  // or when the host withdraws, so grants never come back-to-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (gwe) begin
      if (host_sel || !h_req)
        starve_cnt <= '0;
      else if (p_req && (starve_cnt != STARVE_MAX))
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Host read capture: data sampled on the granting edge, valid pulses one clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_rdata  <= '0;
      h_rvalid <= 1'b0;
    end else begin
      h_rvalid <= h_ack && !h_we;
      if (h_ack && !h_we)
        h_rdata <= mem_dout;
    end
  end

  // Saturating statistics, advanced on gwe edges only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_host_grants <= '0;
      stat_proc_stalls <= '0;
    end else if (gwe) begin
      if (host_sel && (stat_host_grants != CNT_MAX))
        stat_host_grants <= stat_host_grants + CNT_W'(1);
      if (p_stall && (stat_proc_stalls != CNT_MAX))
        stat_proc_stalls <= stat_proc_stalls + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_lc4_dmem_arbiter.sv
// Scoreboard bench for lc4_dmem_arbiter: stimulus pushes expected per-gwe
// results and host read data into queues; a negedge monitor pops and compares.
module tb_lc4_dmem_arbiter;
  localparam int WS = 64;
  localparam int AW = 3;
  localparam int SL = 3;
  localparam int CW = 5;  // small so saturation is reachable

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          gwe = 1'b0;
  logic          p_req = 1'b0, p_we = 1'b0;
  logic [AW-1:0] p_raddr = '0, p_waddr = '0;
  logic [WS-1:0] p_wdata = '0;
  logic [WS-1:0] p_rdata;
  logic          p_stall;
  logic          h_req = 1'b0, h_we = 1'b0;
  logic [AW-1:0] h_addr = '0;
  logic [WS-1:0] h_wdata = '0;
  logic          h_ack, h_rvalid;
  logic [WS-1:0] h_rdata;
  logic [AW-1:0] mem_raddr, mem_waddr;
  logic [WS-1:0] mem_din, mem_dout;
  logic          mem_we;
  logic [CW-1:0] stat_host_grants, stat_proc_stalls;

  always #5 clk = ~clk;

  lc4_dmem_arbiter #(.WORD_SIZE(WS), .REG_ADDR_BITS(AW), .STARVE_LIMIT(SL), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .gwe(gwe),
    .p_req(p_req), .p_we(p_we), .p_raddr(p_raddr), .p_waddr(p_waddr), .p_wdata(p_wdata),
    .p_rdata(p_rdata), .p_stall(p_stall),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_ack(h_ack), .h_rdata(h_rdata), .h_rvalid(h_rvalid),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_din(mem_din), .mem_we(mem_we),
    .mem_dout(mem_dout),
    .stat_host_grants(stat_host_grants), .stat_proc_stalls(stat_proc_stalls)
  );

  // Stand-in for lc4_memory: async read, write on gwe edges.
  logic [WS-1:0] tbmem [8];
  assign mem_dout = tbmem[mem_raddr];
  always @(posedge clk) if (gwe && mem_we) tbmem[mem_waddr] <= mem_din;

  typedef struct {
    logic preq, pwe; logic [AW-1:0] praddr, pwaddr; logic [WS-1:0] pwdata;
    logic hreq, hwe; logic [AW-1:0] haddr;  logic [WS-1:0] hwdata;
  } stim_t;

  typedef struct {
    logic stall, ack, we; logic [AW-1:0] raddr; logic [WS-1:0] prdata;
    logic [CW-1:0] hg, ps;
  } cyc_t;

  cyc_t          cyc_q[$];
  logic [WS-1:0] rd_q[$];

  // Reference model: abstract memory, consecutive-loss count, event totals.
  logic [WS-1:0] ref_mem [8];
  int losses = 0, n_hg = 0, n_ps = 0;
  int vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got unexpected event expected none at %0t", name, $time);
  endtask

  function automatic logic [CW-1:0] sat(input int n);
    if (n >= (1 << CW) - 1) return '1;
    return CW'(n);
  endfunction

  function automatic stim_t mk(input int preq, input int pwe, input int ra, input int wa,
                               input logic [WS-1:0] wd, input int hreq, input int hwe,
                               input int ha, input logic [WS-1:0] hd);
    stim_t s;
    s.preq = preq[0]; s.pwe = pwe[0]; s.praddr = ra[AW-1:0]; s.pwaddr = wa[AW-1:0];
    s.pwdata = wd; s.hreq = hreq[0]; s.hwe = hwe[0]; s.haddr = ha[AW-1:0]; s.hwdata = hd;
    return s;
  endfunction

  // Reset: called at posedge+1; registered outputs must clear at once.
  task automatic do_reset();
    rst_n = 1'b0;
    rd_q.delete();
    losses = 0; n_hg = 0; n_ps = 0;
    #1;
    chk("rst_h_rvalid", 64'(h_rvalid), 64'd0);
    chk("rst_h_rdata", 64'(h_rdata), 64'd0);
    chk("rst_stat_host_grants", 64'(stat_host_grants), 64'd0);
    chk("rst_stat_proc_stalls", 64'(stat_proc_stalls), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One gwe period: gwe clk with stable inputs, then three quiet clks.
  task automatic step(input stim_t s, input bit junk, input bit rst_after, output bit granted);
    cyc_t e;
    bit   g;
    p_req = s.preq; p_we = s.pwe; p_raddr = s.praddr; p_waddr = s.pwaddr; p_wdata = s.pwdata;
    h_req = s.hreq; h_we = s.hwe; h_addr = s.haddr; h_wdata = s.hwdata;
    gwe = 1'b1;
    g = s.hreq && (!s.preq || losses >= SL);
    e.ack = g; e.stall = g && s.preq;
    e.we = g ? s.hwe : (s.preq && s.pwe);
    e.raddr = g ? s.haddr : s.praddr;
    e.prdata = ref_mem[e.raddr];
    e.hg = sat(n_hg); e.ps = sat(n_ps);
    cyc_q.push_back(e);
    if (g && !s.hwe) rd_q.push_back(ref_mem[s.haddr]);
    if (g) begin
      if (s.hwe) ref_mem[s.haddr] = s.hwdata;
      n_hg++;
      if (s.preq) n_ps++;
    end else if (s.preq && s.pwe) ref_mem[s.pwaddr] = s.pwdata;
    if (g || !s.hreq) losses = 0;
    else if (s.preq && losses < SL) losses++;
    granted = g;
    @(posedge clk);
    #1 gwe = 1'b0;
    if (rst_after) begin
      do_reset();
      return;
    end
    for (int k = 0; k < 3; k++) begin
      if (junk) begin
        p_req = 1'($urandom); p_we = 1'($urandom); p_waddr = AW'($urandom);
        p_raddr = AW'($urandom); p_wdata = {$urandom, $urandom};
        h_req = 1'($urandom); h_we = 1'($urandom); h_addr = AW'($urandom);
        h_wdata = {$urandom, $urandom};
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compares against the queued expectations away from the edge.
  always @(negedge clk) begin
    cyc_t e;
    if (gwe) begin
      if (cyc_q.size() == 0) fail("cyc_q_underflow");
      else begin
        e = cyc_q.pop_front();
        chk("p_stall", 64'(p_stall), 64'(e.stall));
        chk("h_ack", 64'(h_ack), 64'(e.ack));
        chk("mem_we", 64'(mem_we), 64'(e.we));
        chk("mem_raddr", 64'(mem_raddr), 64'(e.raddr));
        chk("p_rdata", p_rdata, e.prdata);
        chk("stat_host_grants", 64'(stat_host_grants), 64'(e.hg));
        chk("stat_proc_stalls", 64'(stat_proc_stalls), 64'(e.ps));
      end
    end else begin
      chk("h_ack_off_gwe", 64'(h_ack), 64'd0);
    end
    if (h_rvalid) begin
      if (rd_q.size() == 0) fail("h_rvalid_spurious");
      else chk("h_rdata", h_rdata, rd_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit    g;
    bit    hp;
    stim_t s, hs;
    for (int i = 0; i < 8; i++) begin tbmem[i] = '0; ref_mem[i] = '0; end
    hp = 1'b0;
    hs = mk(0, 0, 0, 0, '0, 0, 0, 0, '0);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 do_reset();

    // Processor store then load of word 5.
    step(mk(1, 1, 0, 5, 64'hDEAD_BEEF_0000_0005, 0, 0, 0, '0), 0, 0, g);
    step(mk(1, 0, 5, 0, '0, 0, 0, 0, '0), 0, 0, g);
    // Host alone reads word 5.
    step(mk(0, 0, 0, 0, '0, 1, 0, 5, '0), 0, 0, g);
    step(mk(0, 0, 0, 0, '0, 0, 0, 0, '0), 0, 0, g);
    // Contention: host write wins on the 4th gwe, then processor wins again.
    repeat (4) step(mk(1, 0, 3, 0, '0, 1, 1, 2, 64'h1), 0, 0, g);
    step(mk(1, 0, 2, 0, '0, 1, 0, 2, '0), 0, 0, g);
    step(mk(1, 0, 0, 0, '0, 0, 0, 0, '0), 0, 0, g);
    // Host drops after 2 losses; re-request needs 3 more.
    repeat (2) step(mk(1, 0, 1, 0, '0, 1, 0, 2, '0), 0, 0, g);
    step(mk(1, 0, 1, 0, '0, 0, 0, 0, '0), 0, 0, g);
    repeat (4) step(mk(1, 0, 1, 0, '0, 1, 0, 2, '0), 0, 0, g);
    // Inputs wiggle between gwe pulses.
    repeat (3) step(mk(0, 0, 2, 0, '0, 0, 0, 0, '0), 1, 0, g);
    repeat (2) step(mk(1, 0, 5, 0, '0, 0, 0, 0, '0), 1, 0, g);
    // Reset with two losses accumulated, then contention needs 3 wins.
    step(mk(1, 0, 4, 0, '0, 1, 1, 6, 64'h66), 0, 0, g);
    step(mk(1, 0, 4, 0, '0, 1, 1, 6, 64'h66), 0, 1, g);
    repeat (4) step(mk(1, 0, 6, 0, '0, 1, 1, 6, 64'h66), 0, 0, g);
    // Reset with a host read valid pending.
    step(mk(0, 0, 0, 0, '0, 1, 0, 6, '0), 0, 1, g);
    repeat (4) step(mk(1, 0, 6, 0, '0, 1, 0, 5, '0), 0, 0, g);

    // Randomized traffic with a host agent that holds requests until acked.
    for (int i = 0; i < 600; i++) begin
      s = mk(0, 0, 0, 0, '0, 0, 0, 0, '0);
      s.preq = ($urandom_range(0, 9) < 8);
      s.pwe = 1'($urandom); s.praddr = AW'($urandom); s.pwaddr = AW'($urandom);
      s.pwdata = {$urandom, $urandom};
      if (!hp && $urandom_range(0, 9) < 8) begin
        hp = 1'b1;
        hs.hwe = 1'($urandom); hs.haddr = AW'($urandom); hs.hwdata = {$urandom, $urandom};
      end else if (hp && $urandom_range(0, 31) == 0) begin
        hp = 1'b0;
      end
      s.hreq = hp; s.hwe = hs.hwe; s.haddr = hs.haddr; s.hwdata = hs.hwdata;
      step(s, $urandom_range(0, 3) == 0, 0, g);
      if (g) hp = 1'b0;
    end
    step(mk(0, 0, 0, 0, '0, 0, 0, 0, '0), 0, 0, g);
    repeat (2) @(posedge clk);
    #1;
    chk("cyc_q_drained", 64'(cyc_q.size()), 64'd0);
    chk("rd_q_drained", 64'(rd_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
